// File: rtl/zap_shifter_divide_pkg.sv
// Shared definitions for the shifter-stage divider: opcode numbers,
// controller state encoding and the operand magnitude helper.
package zap_shifter_divide_pkg;

    // ALU opcode numbers that start the divider.
    localparam int OP_UDIV = 22;
    localparam int OP_SDIV = 23;

    // Divider controller states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // Magnitude of a 32-bit operand as unsigned. The most negative value
    // maps to 0x80000000, which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
        logic signed [31:0] s;
        s = v;
        if (is_signed && s < 0) begin
            return 32'(-s);
        end
        return v;
    endfunction

endpackage

// File: rtl/zap_divide_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// subtract the divisor when it fits and produce one quotient bit.
module zap_divide_step (
    input  logic [32:0] i_rem,
    input  logic        i_bit,
    input  logic [31:0] i_divisor,
    output logic [32:0] o_rem,
    output logic        o_qbit
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_unused;

    // The partial remainder always stays below the divisor, so its top bit
    // is zero on entry and falls off in the shift.
    assign w_unused = i_rem[32];

    assign w_shift = {i_rem[31:0], i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_qbit  = (w_shift >= {1'b0, i_divisor});
    assign o_rem   = o_qbit ? w_diff : w_shift;

endmodule

// File: rtl/zap_shifter_divide.sv
// Iterative 32/32 divider for UDIV/SDIV in the shifter stage. One quotient
// bit per cycle using unsigned magnitudes; the sign is applied at the end.
module zap_shifter_divide
    import zap_shifter_divide_pkg::*;
#(
    parameter int ALU_OPS = 32'd32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clear_from_writeback,
    input  logic                       i_data_stall,
    input  logic                       i_clear_from_alu,
    input  logic [$clog2(ALU_OPS)-1:0] i_alu_operation_ff,
    input  logic                       i_cc_satisfied,
    input  logic [31:0]                i_rn,
    input  logic [31:0]                i_rm,
    output logic [31:0]                o_rd,
    output logic                       o_busy,
    output logic                       o_dbz
);

    localparam int OP_W = $clog2(ALU_OPS);
    localparam logic [OP_W-1:0] L_UDIV = OP_W'(OP_UDIV);
    localparam logic [OP_W-1:0] L_SDIV = OP_W'(OP_SDIV);

    div_state_t  r_state;
    div_state_t  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_dbz;

    logic        w_is_sdiv;
    logic        w_start;
    logic        w_rm_zero;
    logic [31:0] w_rn_mag;
    logic [31:0] w_rm_mag;
    logic [32:0] w_rem_nxt;
    logic        w_qbit;

    assign w_is_sdiv = (i_alu_operation_ff == L_SDIV);
    assign w_start   = i_cc_satisfied &&
                       ((i_alu_operation_ff == L_UDIV) || w_is_sdiv);
    assign w_rm_zero = (i_rm == 32'd0);
    assign w_rn_mag  = f_mag(i_rn, w_is_sdiv);
    assign w_rm_mag  = f_mag(i_rm, w_is_sdiv);

    zap_divide_step u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quot[31]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    // Next-state and output decode; outputs follow the (possibly held) state.
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_rd        = 32'd0;
        o_dbz       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    o_busy      = 1'b1;
                    w_state_nxt = PREP;
                end
            end
            PREP: begin
                o_busy      = 1'b1;
                w_state_nxt = w_rm_zero ? DONE : ITER;
            end
            ITER: begin
                o_busy = 1'b1;
                if (r_cnt == 5'd0) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                o_busy      = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                o_rd        = r_quot;
                o_dbz       = r_dbz;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = div_state_t'('x);
                o_busy      = 1'bx;
                o_rd        = 'x;
                o_dbz       = 1'bx;
            end
        endcase
    end

    // State register: writeback flush beats the stall, ALU flush does not.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else if (i_clear_from_writeback) begin
            r_state <= IDLE;
        end else if (i_clear_from_alu && !i_data_stall) begin
            r_state <= IDLE;
        end else if (!i_data_stall) begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operand capture, shift/subtract iterations and sign fix-up.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= 5'd0;
            r_rem     <= 33'd0;
            r_quot    <= 32'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (!i_data_stall) begin
            case (r_state)
                PREP: begin
                    r_divisor <= w_rm_mag;
                    r_neg_q   <= w_is_sdiv & (i_rn[31] ^ i_rm[31]);
                    r_rem     <= 33'd0;
                    // A zero divisor skips the iterations; report quotient 0.
                    r_quot    <= w_rm_zero ? 32'd0 : w_rn_mag;
                    r_cnt     <= 5'd31;
                    r_dbz     <= w_rm_zero;
                end
                ITER: begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= {r_quot[30:0], w_qbit};
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                FIX: begin
                    if (r_neg_q) begin
                        r_quot <= ~r_quot + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_shifter_divide.sv
// Directed bench for zap_shifter_divide with a cycle-level expectation
// model and a single compare process on the falling clock edge.
module tb_zap_shifter_divide;
    import zap_shifter_divide_pkg::*;

    localparam logic [4:0] UDIV = 5'(OP_UDIV);
    localparam logic [4:0] SDIV = 5'(OP_SDIV);

    logic        clk = 1'b0;
    logic        rst;
    logic        wbclr;
    logic        stall;
    logic        aluclr;
    logic [4:0]  op;
    logic        cc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] rd;
    logic        busy;
    logic        dbz;

    int          errs   = 0;
    int          checks = 0;
    logic        chk_en = 1'b0;
    logic        exp_busy;
    logic [31:0] exp_rd;
    logic        exp_dbz;
    string       tname;

    zap_shifter_divide #(.ALU_OPS(32)) dut (
        .i_clk                  (clk),
        .i_reset                (rst),
        .i_clear_from_writeback (wbclr),
        .i_data_stall           (stall),
        .i_clear_from_alu       (aluclr),
        .i_alu_operation_ff     (op),
        .i_cc_satisfied         (cc),
        .i_rn                   (rn),
        .i_rm                   (rm),
        .o_rd                   (rd),
        .o_busy                 (busy),
        .o_dbz                  (dbz)
    );

    always #5 clk = ~clk;

    // Compare process: every checked cycle, outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== exp_busy || rd !== exp_rd || dbz !== exp_dbz) begin
                errs++;
                $display("FAIL %s @%0t: got busy=%0b rd=%08h dbz=%0b, want busy=%0b rd=%08h dbz=%0b",
                         tname, $time, busy, rd, dbz, exp_busy, exp_rd, exp_dbz);
            end
        end
    end

    // Architectural result: truncating division on 64-bit integers.
    function automatic logic [31:0] model_q(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        if (b == 32'd0) return 32'd0;
        if (o == SDIV) begin
            x = longint'(signed'(a));
            y = longint'(signed'(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        return q[31:0];
    endfunction

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %08h, want %08h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic b, input logic [31:0] r, input logic z);
        exp_busy = b;
        exp_rd   = r;
        exp_dbz  = z;
    endtask

    task automatic idle_cycles(input string name, input logic [4:0] o, input logic c, input int n);
        tname = name;
        op = o; cc = c; stall = 1'b0; aluclr = 1'b0; wbclr = 1'b0;
        rn = 32'd50; rm = 32'd5;
        set_exp(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    // Runs one operation from its start cycle. Optional stall window (with
    // an ALU flush on its first cycle), writeback flush, or async reset.
    task automatic do_op(input string name, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit_q, input logic lit_dbz,
                         input int stall_at, input int stall_len, input logic alu_clr,
                         input int wb_at, input int rst_at);
        logic [31:0] q;
        logic        z;
        int          total;
        q     = model_q(o, a, b);
        z     = (b == 32'd0);
        total = (z ? 2 : 35) + stall_len;
        tname = name;
        cc    = 1'b1;
        for (int k = 0; k <= total; k++) begin
            if (k <= 1) begin
                op = o; rn = a; rm = b;
            end else begin
                op = 5'd0; rn = $urandom; rm = $urandom;
            end
            stall  = (k >= stall_at) && (k < stall_at + stall_len);
            aluclr = alu_clr && (k == stall_at);
            wbclr  = (k == wb_at);
            if (k < total) begin
                set_exp(1'b1, 32'd0, 1'b0);
            end else begin
                set_exp(1'b0, q, z);
                #1;
                check_lit({name, "_rd"}, rd, lit_q);
                check_lit({name, "_dbz"}, {31'd0, dbz}, {31'd0, lit_dbz});
            end
            if (k == rst_at) begin
                #2;
                rst = 1'b1;
                op  = 5'd0;
                set_exp(1'b0, 32'd0, 1'b0);
                #1;
                check_lit({name, "_async_busy"}, {31'd0, busy}, 32'd0);
                check_lit({name, "_async_rd"}, rd, 32'd0);
                step();
                rst = 1'b0;
                return;
            end
            step();
            if (k == wb_at) begin
                wbclr = 1'b0; stall = 1'b0; aluclr = 1'b0; op = 5'd0;
                set_exp(1'b0, 32'd0, 1'b0);
                check_lit({name, "_flush_busy"}, {31'd0, busy}, 32'd0);
                return;
            end
        end
        op = 5'd0; stall = 1'b0; aluclr = 1'b0; wbclr = 1'b0;
        set_exp(1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wbclr = 1'b0; stall = 1'b0; aluclr = 1'b0;
        op = 5'd0; cc = 1'b0; rn = 32'd0; rm = 32'd0;
        tname = "reset";
        set_exp(1'b0, 32'd0, 1'b0);
        step();
        chk_en = 1'b1;
        step();
        check_lit("reset_rd", rd, 32'd0);
        rst = 1'b0;
        step();

        do_op("udiv_100_7",  UDIV, 32'd100,        32'd7,          32'd14,         1'b0, -1, 0, 1'b0, -1, -1);
        idle_cycles("gap", 5'd0, 1'b0, 2);
        do_op("sdiv_m100_7", SDIV, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0, -1, 0, 1'b0, -1, -1);
        do_op("sdiv_100_m7", SDIV, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0, -1, 0, 1'b0, -1, -1);
        do_op("sdiv_m100_m7",SDIV, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0, -1, 0, 1'b0, -1, -1);
        do_op("sdiv_3_m7",   SDIV, 32'd3,          32'hFFFFFFF9,   32'd0,          1'b0, -1, 0, 1'b0, -1, -1);
        do_op("udiv_dbz",    UDIV, 32'd123,        32'd0,          32'd0,          1'b1, -1, 0, 1'b0, -1, -1);
        do_op("sdiv_dbz",    SDIV, 32'hFFFFFFFB,   32'd0,          32'd0,          1'b1, -1, 0, 1'b0, -1, -1);
        do_op("sdiv_min_m1", SDIV, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, -1, 0, 1'b0, -1, -1);
        do_op("udiv_max_1",  UDIV, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0, -1, 0, 1'b0, -1, -1);
        do_op("udiv_max_3",  UDIV, 32'hFFFFFFFF,   32'd3,          32'h55555555,   1'b0, -1, 0, 1'b0, -1, -1);
        do_op("udiv_stall",  UDIV, 32'd1000,       32'd10,         32'd100,        1'b0, 14, 5, 1'b0, -1, -1);
        do_op("wb_flush",    UDIV, 32'd1000,       32'd10,         32'd100,        1'b0, 12, 1, 1'b0, 12, -1);
        do_op("udiv_9_3_aluclr", UDIV, 32'd9,      32'd3,          32'd3,          1'b0, 5, 1, 1'b1, -1, -1);
        do_op("async_reset", UDIV, 32'd1000,       32'd7,          32'd142,        1'b0, -1, 0, 1'b0, -1, 20);
        do_op("udiv_7_2",    UDIV, 32'd7,          32'd2,          32'd3,          1'b0, -1, 0, 1'b0, -1, -1);

        idle_cycles("idle_udiv_cc0", UDIV, 1'b0, 4);
        idle_cycles("idle_sdiv_cc0", SDIV, 1'b0, 4);
        idle_cycles("idle_other_op", 5'd3, 1'b1, 4);
        idle_cycles("idle_end",      5'd0, 1'b0, 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/zap_shifter_divide.md
Name: zap_shifter_divide

Overview:
- Iterative 32/32 integer divider for ARM UDIV/SDIV; the inverse operation of the shifter-stage multiplier.
- Sits in the shifter stage beside the multiplier and shares its clear/stall/busy conventions.
- Radix-2 restoring algorithm, one quotient bit per cycle. Delivers a 32-bit quotient to the ALU with truncation toward zero.

Parameters:
- ALU_OPS, 32'd32, number of ALU opcodes; sets the width of i_alu_operation_ff.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  reset; asynchronous, active-high.
- i_clear_from_writeback  input  1  pipeline flush, highest priority after reset.
- i_data_stall  input  1  freeze all state.
- i_clear_from_alu  input  1  flush; effective only when not stalled.
- i_alu_operation_ff  input  $clog2(ALU_OPS)  opcode; OP_UDIV or OP_SDIV starts the unit.
- i_cc_satisfied  input  1  condition passed; required to start.
- i_rn  input  32  dividend.
- i_rm  input  32  divisor.
- o_rd  output  32  quotient; valid only in the DONE cycle, else 0.
- o_busy  output  1  unit busy; the pipeline holds while this is high.
- o_dbz  output  1  divide-by-zero indication; pulses in the DONE cycle.

Behaviour:
- Reset (async, i_reset=1):
  - state=IDLE; counter, remainder, quotient and sign flags cleared.
  - Outputs: o_rd=0, o_busy=0, o_dbz=0.
- Register update priority: i_reset > i_clear_from_writeback > (i_clear_from_alu && !i_data_stall) > !i_data_stall.
  - Both clears force IDLE and drop the in-flight operation; datapath contents are don't-care.
  - i_data_stall=1 holds every register. Outputs stay a combinational function of the held state.
- States:
  - IDLE: o_busy=0.
    - If i_cc_satisfied and op is OP_UDIV or OP_SDIV: o_busy=1 in this same cycle, next state PREP.
  - PREP: o_busy=1.
    - Latch the operands. For SDIV, take absolute values as 32-bit unsigned and record neg_q = rn[31]^rm[31]. For UDIV, neg_q=0.
    - Clear remainder (33-bit), load quotient register with |rn|, set counter=31.
    - If rm==0, next state DONE with dbz flag set; otherwise next state ITER.
  - ITER: o_busy=1. Each cycle:
    - r' = {r[31:0], q[31]}.
    - If r' >= {1'b0,|rm|}: r' -= |rm|, new q bit 1; otherwise new q bit 0.
    - q = {q[30:0], bit}.
    - At counter==0, next state FIX; otherwise counter decrements.
    - Exactly 32 ITER cycles.
  - FIX: o_busy=1. Quotient becomes neg_q ? (~q+1) : q. Next state DONE.
  - DONE: o_busy=0, o_rd=quotient, o_dbz=dbz flag. Next state IDLE.
    - A new op is not accepted in DONE; it is accepted in the following IDLE cycle.
  - Any other state encoding: all outputs and next-state are 'x.
- Latency, unstalled, from the start cycle to the DONE cycle:
  - Normal operation: 35 cycles with o_busy=1, then 1 DONE cycle.
  - Divide-by-zero: 2 busy cycles (IDLE-start, PREP), then DONE.
- Arithmetic:
  - Divide by zero returns 0 with o_dbz=1; no trap.
  - SDIV 0x80000000 / 0xFFFFFFFF returns 0x80000000, handled naturally by unsigned magnitude arithmetic with no special case.
  - Quotient sign follows neg_q; quotient 0 stays 0 after negation.
  - No remainder output.
- i_rn, i_rm and i_alu_operation_ff must be stable only in the IDLE-start and PREP cycles. Later changes are ignored.
- A stall in the IDLE-start cycle prevents the move to PREP. o_busy stays high while start conditions hold.

Decomposition:
- Shared package / zap_localparams.svh: OP_UDIV and OP_SDIV opcode constants, and the state enum typedef (IDLE, PREP, ITER, FIX, DONE).
- One combinational sub-module, zap_divide_step.
  - Inputs: 33-bit remainder, next dividend bit, 32-bit divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once; keeps the subtract/compare isolated for timing.

Test Plan:
- UDIV rn=100, rm=7, cc=1: o_busy high 35 cycles, then o_rd=14, o_dbz=0 for 1 cycle, then o_busy=0 and o_rd=0.
- SDIV rn=0xFFFFFF9C (-100), rm=7: o_rd=0xFFFFFFF2 (-14). SDIV rn=100, rm=0xFFFFFFF9: o_rd=0xFFFFFFF2.
- UDIV/SDIV rm=0: o_busy high 2 cycles, then o_rd=0, o_dbz=1. SDIV 0x80000000/0xFFFFFFFF: o_rd=0x80000000. UDIV 0xFFFFFFFF/1: o_rd=0xFFFFFFFF.
- UDIV 1000/10 with i_data_stall=1 for 5 cycles at iteration 12: o_busy high 40 cycles, o_rd=100. During the stall, state and outputs are unchanged.
- i_clear_from_writeback at iteration 10 (with stall=1): IDLE next cycle, o_busy=0. Then UDIV 9/3 completes with o_rd=3. i_clear_from_alu together with stall=1 is ignored.
- Async i_reset asserted mid-ITER between clock edges: o_busy=0 and o_rd=0 immediately, without waiting for a clock edge. Idle with a non-divide op or cc=0: o_busy never rises.
